// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared geometry defaults, counter/state types for the branch predictor
package bpu_pkg;

  localparam int DEF_PC_HASH_BITS   = 3;
  localparam int DEF_PHT_INDEX_BITS = 7;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_cnt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } bpu_state_t;

  localparam pht_cnt_t PHT_RESET = WNT;

  function automatic logic cnt_taken(input pht_cnt_t c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down counter, combinational next state
module sat_counter2
  import bpu_pkg::*;
(
  input  pht_cnt_t cnt,
  input  logic     inc,
  output pht_cnt_t cnt_next
);

  logic [1:0] cnt_raw;

  assign cnt_raw = cnt;

  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      if (cnt != ST) cnt_next = pht_cnt_t'(cnt_raw + 2'd1);
    end else begin
      if (cnt != SNT) cnt_next = pht_cnt_t'(cnt_raw - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// rtl/branch_predictor_ctrl.sv - two-level local branch predictor with table flush; BPU_PERF_CNT_EN adds perf counters
module branch_predictor_ctrl
  import bpu_pkg::*;
#(
  parameter int PC_HASH_BITS   = DEF_PC_HASH_BITS,
  parameter int PHT_INDEX_BITS = DEF_PHT_INDEX_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pcF,
  output logic                      predict_takeF,
  output logic [PC_HASH_BITS-1:0]   pc_hashingF,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  input  logic                      branchM,
  input  logic                      actually_takenM,
  input  logic [PC_HASH_BITS-1:0]   pc_hashingM,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexM,
  input  logic                      predict_resultM,
  input  logic                      flush_tables,
  output logic                      busy
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]               branch_cnt,
  output logic [31:0]               mispredict_cnt
`endif
);

  localparam int HIST_BITS = PHT_INDEX_BITS - PC_HASH_BITS;
  localparam int BHT_DEPTH = 1 << PC_HASH_BITS;
  localparam int PHT_DEPTH = 1 << PHT_INDEX_BITS;
  localparam int IDX_W     = PHT_INDEX_BITS + 1;
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(PHT_DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_BHT_END = IDX_W'(BHT_DEPTH);

  if (HIST_BITS < 1) begin : g_bad_geometry
    $error("branch_predictor_ctrl: PHT_INDEX_BITS must exceed PC_HASH_BITS");
  end

  logic [HIST_BITS-1:0] bht [BHT_DEPTH];
  pht_cnt_t             pht [PHT_DEPTH];

  bpu_state_t           state;
  logic [IDX_W-1:0]     idx;
  logic                 accept;
  logic [HIST_BITS-1:0] hist_next;
  pht_cnt_t             pht_next;
  logic                 unused_pc;

  // Fetch side reads the tables as they stand; a same-cycle update is not bypassed.
  assign pc_hashingF   = pcF[PC_HASH_BITS+1:2];
  assign PHT_indexF    = {pc_hashingF, bht[pc_hashingF]};
  assign predict_takeF = (state == IDLE) && cnt_taken(pht[PHT_indexF]);
  assign unused_pc     = ^{pcF[31:PC_HASH_BITS+2], pcF[1:0]};

  assign accept = branchM && (state == IDLE);

  if (HIST_BITS == 1) begin : g_hist1
    assign hist_next = actually_takenM;
  end else begin : g_histn
    assign hist_next = {bht[pc_hashingM][HIST_BITS-2:0], actually_takenM};
  end

  sat_counter2 u_pht_cnt (
    .cnt      (pht[PHT_indexM]),
    .inc      (actually_takenM),
    .cnt_next (pht_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= PHT_RESET;
    end else if (state == SWEEP) begin
      pht[idx[PHT_INDEX_BITS-1:0]] <= PHT_RESET;
      if (idx < IDX_BHT_END) bht[idx[PC_HASH_BITS-1:0]] <= '0;
    end else if (accept) begin
      pht[PHT_indexM]  <= pht_next;
      bht[pc_hashingM] <= hist_next;
    end
  end

  // Sweep sequencer: a new flush pulse always restarts from entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_tables) begin
            state <= SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (flush_tables) begin
            idx <= '0;
          end else if (idx == IDX_LAST) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BPU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (flush_tables) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (accept) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (!predict_resultM) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = predict_resultM;
`endif

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// tb/tb_branch_predictor_ctrl.sv - directed and randomized checks of branch_predictor_ctrl against a table model
module tb_branch_predictor_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        predict_takeF;
  logic [2:0]  pc_hashingF;
  logic [6:0]  PHT_indexF;
  logic        branchM;
  logic        actually_takenM;
  logic [2:0]  pc_hashingM;
  logic [6:0]  PHT_indexM;
  logic        predict_resultM;
  logic        flush_tables;
  logic        busy;
`ifdef BPU_PERF_CNT_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int bht_m [8];
  int pht_m [128];
  bit busy_m;
  int sweep_pos;
  int brc_m;
  int misc_m;
  bit busy_seen;
  bit pred_seen;
  int n;
  int ph;

  branch_predictor_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .pcF             (pcF),
    .predict_takeF   (predict_takeF),
    .pc_hashingF     (pc_hashingF),
    .PHT_indexF      (PHT_indexF),
    .branchM         (branchM),
    .actually_takenM (actually_takenM),
    .pc_hashingM     (pc_hashingM),
    .PHT_indexM      (PHT_indexM),
    .predict_resultM (predict_resultM),
    .flush_tables    (flush_tables),
    .busy            (busy)
`ifdef BPU_PERF_CNT_EN
    ,
    .branch_cnt      (branch_cnt),
    .mispredict_cnt  (mispredict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (bht_m[i]) bht_m[i] = 0;
    foreach (pht_m[i]) pht_m[i] = 1;
    busy_m    = 1'b0;
    sweep_pos = 0;
    brc_m     = 0;
    misc_m    = 0;
  endfunction

  task automatic check_outputs();
    int h;
    int ix;
    h  = int'(pcF[4:2]);
    ix = h * 16 + bht_m[h];
    chk("pc_hashingF", 32'(pc_hashingF), h);
    chk("PHT_indexF", 32'(PHT_indexF), ix);
    chk("predict_takeF", 32'(predict_takeF), (!busy_m && pht_m[ix] >= 2) ? 1 : 0);
    chk("busy", 32'(busy), busy_m ? 1 : 0);
`ifdef BPU_PERF_CNT_EN
    chk("branch_cnt", branch_cnt, brc_m);
    chk("mispredict_cnt", mispredict_cnt, misc_m);
`endif
    busy_seen = busy;
    pred_seen = predict_takeF;
  endtask

  function automatic void model_edge(input bit br, input bit t, input int hm, input int im,
                                     input bit pr, input bit fl);
    bit acc;
    acc = br && !busy_m;
    if (busy_m) begin
      pht_m[sweep_pos] = 1;
      if (sweep_pos < 8) bht_m[sweep_pos] = 0;
    end else if (acc) begin
      if (t) pht_m[im] = (pht_m[im] == 3) ? 3 : pht_m[im] + 1;
      else   pht_m[im] = (pht_m[im] == 0) ? 0 : pht_m[im] - 1;
      bht_m[hm] = ((bht_m[hm] << 1) | int'(t)) % 16;
    end
    if (fl) begin
      busy_m    = 1'b1;
      sweep_pos = 0;
    end else if (busy_m) begin
      if (sweep_pos == 127) busy_m = 1'b0;
      else sweep_pos++;
    end
    if (fl) begin
      brc_m  = 0;
      misc_m = 0;
    end else if (acc) begin
      brc_m++;
      if (!pr) misc_m++;
    end
  endfunction

  task automatic step(input logic [31:0] pc, input bit br, input bit t, input int hm,
                      input int im, input bit pr, input bit fl);
    @(negedge clk);
    pcF             = pc;
    branchM         = br;
    actually_takenM = t;
    pc_hashingM     = 3'(hm);
    PHT_indexM      = 7'(im);
    predict_resultM = pr;
    flush_tables    = fl;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(br, t, hm, im, pr, fl);
  endtask

  task automatic async_reset();
    @(negedge clk);
    branchM      = 1'b0;
    flush_tables = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_busy", 32'(busy), 0);
`ifdef BPU_PERF_CNT_EN
    chk("async_rst_branch_cnt", branch_cnt, 0);
    chk("async_rst_mispredict_cnt", mispredict_cnt, 0);
`endif
    check_outputs();
    #1 rst = 1'b1;
  endtask

  initial begin
    rst             = 1'b0;
    pcF             = 32'h10;
    branchM         = 1'b0;
    actually_takenM = 1'b0;
    pc_hashingM     = '0;
    PHT_indexM      = '0;
    predict_resultM = 1'b1;
    flush_tables    = 1'b0;
    model_reset();

    #12;
    chk("rst_hash", 32'(pc_hashingF), 32'h4);
    chk("rst_index", 32'(PHT_indexF), 32'h40);
    chk("rst_pred", 32'(predict_takeF), 0);
    chk("rst_busy", 32'(busy), 0);
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Training: BHT[4] becomes 0011, PHT[0x40] climbs to strongly taken.
    step(32'h10, 1, 1, 4, 'h40, 1, 0);
    step(32'h10, 1, 1, 4, 'h40, 1, 0);
    #2;
    chk("train_index", 32'(PHT_indexF), 32'h43);
    chk("train_pred", 32'(predict_takeF), 0);

    step(32'h10, 1, 1, 5, 'h43, 1, 0);
    step(32'h10, 1, 1, 5, 'h43, 1, 0);
    #2;
    chk("strong_taken_pred", 32'(predict_takeF), 1);

    for (int i = 0; i < 6; i++) step(32'h10, 1, 0, 5, 'h43, 0, 0);
    #2;
    chk("sat_low_pred", 32'(predict_takeF), 0);
    step(32'h10, 1, 1, 5, 'h43, 1, 0);
    #2;
    chk("sat_floor_pred", 32'(predict_takeF), 0);

    // Same-cycle update and fetch of entry 0x43 (01 -> 10).
    @(negedge clk);
    pcF = 32'h10; branchM = 1'b1; actually_takenM = 1'b1; pc_hashingM = 3'd5;
    PHT_indexM = 7'h43; predict_resultM = 1'b1; flush_tables = 1'b0;
    #1;
    chk("same_cycle_old", 32'(predict_takeF), 0);
    check_outputs();
    @(posedge clk);
    model_edge(1, 1, 5, 'h43, 1, 0);
    #2;
    chk("same_cycle_new", 32'(predict_takeF), 1);

    // Single flush pulse with a branch presented mid-sweep.
    step(32'h10, 0, 0, 0, 0, 1, 1);
    n = 0;
    ph = 0;
    for (int i = 0; i < 400; i++) begin
      step($urandom, (i == 20), 1, 4, 'h43, 1, 0);
      if (!busy_seen) break;
      n++;
      if (pred_seen) ph++;
    end
    chk("flush_busy_cycles", n, 128);
    chk("sweep_pred_zero", ph, 0);
    for (int h = 0; h < 8; h++) begin
      step(32'(h << 2), 0, 0, 0, 0, 1, 0);
      #2;
      chk("post_flush_index", 32'(PHT_indexF), h * 16);
      chk("post_flush_pred", 32'(predict_takeF), 0);
    end

    // Second pulse 50 cycles into the sweep restarts it.
    step(32'h10, 0, 0, 0, 0, 1, 1);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      step($urandom, 0, 0, 0, 0, 1, (i == 49));
      if (!busy_seen) break;
      n++;
    end
    chk("restart_busy_cycles", n, 178);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end

    // Asynchronous reset in the middle of a sweep.
    step(32'h10, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) step($urandom, 0, 0, 0, 0, 1, 0);
    async_reset();
    step(32'h10, 0, 0, 0, 0, 1, 0);
    #2;
    chk("post_reset_index", 32'(PHT_indexF), 32'h40);

`ifdef BPU_PERF_CNT_EN
    for (int i = 0; i < 10; i++) begin
      step(32'h24, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 127)), !(i == 2 || i == 5 || i == 7), 0);
    end
    #2;
    chk("perf_branch_cnt", branch_cnt, 10);
    chk("perf_mispredict_cnt", mispredict_cnt, 3);
    async_reset();
`endif

    step(32'h10, 0, 0, 0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
